// File: rtl/hex_disp_pkg.sv
// Shared widths, state encoding and blank constant for the hex display arbiter.
package hex_disp_pkg;
    localparam int HEX_W    = 24;
    localparam int DIGITS   = 6;
    localparam int NIBBLE_W = 4;

    typedef enum logic {IDLE, DWELL} state_t;

    localparam logic [DIGITS-1:0] BLANK_ALL = 6'h3F;
endpackage

// File: rtl/hex_display_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from last_owner+1 with wrap,
// optionally masking one index so the current owner can be skipped at dwell expiry.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   last_owner,
    input  logic               exclude_en,
    input  logic [SRC_W-1:0]   exclude_idx,
    output logic               any_valid,
    output logic [SRC_W-1:0]   winner_idx,
    output logic [NUM_REQ-1:0] winner_onehot
);
    int               idx;
    logic [SRC_W-1:0] cand;

    always_comb begin
        any_valid     = 1'b0;
        winner_idx    = '0;
        winner_onehot = '0;
        idx           = 0;
        cand          = '0;
        // k = NUM_REQ lands on last_owner itself, so it is checked last
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_owner) + k) % NUM_REQ;
            cand = idx[SRC_W-1:0];
            if (!any_valid && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
                any_valid           = 1'b1;
                winner_idx          = cand;
                winner_onehot[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the six-digit hex display with a minimum dwell per grant;
// the display bus is registered so the segment driver only sees one source at a time.
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SRC_W        = $clog2(NUM_REQ)
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*HEX_W-1:0]  req_hex,
    input  logic [NUM_REQ*DIGITS-1:0] req_blank,
    output logic [NUM_REQ-1:0]        grant,
    output logic [HEX_W-1:0]          disp_hex,
    output logic [DIGITS-1:0]         disp_blank,
    output logic [SRC_W-1:0]          disp_src,
    output logic                      busy
);
    localparam int               CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [SRC_W-1:0]    last_owner;
    logic [NUM_REQ-1:0]  grant_n;
    logic                any_valid;
    logic [SRC_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_oh;
    logic                load;
    logic                capture;
    logic [SRC_W-1:0]    sel_idx;
    logic [HEX_W-1:0]    sel_hex;
    logic [DIGITS-1:0]   sel_blank;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_picker (
        .req           (req),
        .last_owner    (last_owner),
        .exclude_en    (state == DWELL),
        .exclude_idx   (disp_src),
        .any_valid     (any_valid),
        .winner_idx    (win_idx),
        .winner_onehot (win_oh)
    );

    assign sel_hex   = req_hex[HEX_W*sel_idx +: HEX_W];
    assign sel_blank = req_blank[DIGITS*sel_idx +: DIGITS];
    assign busy      = (state == DWELL);

    always_comb begin
        state_n = state;
        grant_n = grant;
        load    = 1'b0;
        capture = 1'b0;
        sel_idx = disp_src;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_n = DWELL;
                    grant_n = win_oh;
                    load    = 1'b1;
                    sel_idx = win_idx;
                end
            end
            DWELL: begin
                if (cnt == '0) begin
                    // owner is masked in the picker, so any_valid means a different requester
                    if (any_valid) begin
                        grant_n = win_oh;
                        load    = 1'b1;
                        sel_idx = win_idx;
                    end else if (req[disp_src]) begin
                        load    = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end else begin
                    capture = req[disp_src];
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= SRC_W'(NUM_REQ - 1);
            grant      <= '0;
            disp_hex   <= '0;
            disp_blank <= BLANK_ALL;
            disp_src   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            if (load) begin
                cnt        <= CNT_RELOAD;
                disp_src   <= sel_idx;
                last_owner <= sel_idx;
            end else if (state == DWELL && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (load || capture) begin
                disp_hex   <= sel_hex;
                disp_blank <= sel_blank;
            end
        end
    end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scenario tasks for the hex display arbiter, checked against an ownership-level
// reference model (owner, remaining dwell, round-robin search) plus fixed expectations.
module tb_hex_display_arbiter;
    localparam int N = 4;
    localparam int D = 4;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*24-1:0] req_hex;
    logic [N*6-1:0]  req_blank;
    logic [N-1:0]  grant;
    logic [23:0]   disp_hex;
    logic [5:0]    disp_blank;
    logic [1:0]    disp_src;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int          m_owner, m_last, m_rem, m_src;
    logic [23:0] m_hex;
    logic [5:0]  m_blank;

    hex_display_arbiter #(
        .NUM_REQ      (N),
        .DWELL_CYCLES (D)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .req        (req),
        .req_hex    (req_hex),
        .req_blank  (req_blank),
        .grant      (grant),
        .disp_hex   (disp_hex),
        .disp_blank (disp_blank),
        .disp_src   (disp_src),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int rr_find(input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (req[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    task automatic m_load(input int w);
        m_hex   = req_hex[24*w +: 24];
        m_blank = req_blank[6*w +: 6];
    endtask

    task automatic m_give(input int w);
        m_owner = w;
        m_last  = w;
        m_rem   = D - 1;
        m_src   = w;
        m_load(w);
    endtask

    task automatic model_step();
        int w;
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_rem = 0; m_src = 0;
            m_hex = 24'h0; m_blank = 6'h3F;
        end else if (m_owner < 0) begin
            w = rr_find(m_last, -1);
            if (w >= 0) m_give(w);
        end else if (m_rem > 0) begin
            m_rem--;
            if (req[m_owner]) m_load(m_owner);
        end else begin
            w = rr_find(m_owner, m_owner);
            if (w >= 0) m_give(w);
            else if (req[m_owner]) m_give(m_owner);
            else m_owner = -1;
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_hex[24*i +: 24] = 24'($urandom);
            req_blank[6*i +: 6] = 6'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rand_data();
        do_reset();
        total++;
        if (grant !== 4'b0000 || disp_hex !== 24'h000000 || disp_blank !== 6'h3F ||
            busy !== 1'b0 || disp_src !== 2'd0) begin
            bad++;
            $display("FAIL reset_values: grant=%b hex=%h blank=%h busy=%b src=%0d want 0000/000000/3f/0/0",
                     grant, disp_hex, disp_blank, busy, disp_src);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (grant !== 4'b0000 || busy !== 1'b0 || disp_blank !== 6'h3F || disp_hex !== 24'h0) begin
                bad++;
                $display("FAIL idle_hold c=%0d: grant=%b busy=%b blank=%h hex=%h want 0000/0/3f/000000",
                         c, grant, busy, disp_blank, disp_hex);
            end
        end
    endtask

    task automatic test_single();
        rand_data();
        req_hex[48 +: 24] = 24'h0BEEF0;
        req_blank[12 +: 6] = 6'h00;
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100 || disp_hex !== 24'h0BEEF0 || disp_src !== 2'd2 ||
            busy !== 1'b1 || disp_blank !== 6'h00) begin
            bad++;
            $display("FAIL single_first: grant=%b hex=%h src=%0d busy=%b blank=%h want 0100/0beef0/2/1/00",
                     grant, disp_hex, disp_src, busy, disp_blank);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (grant !== 4'b0100 || busy !== 1'b1 || disp_hex !== 24'h0BEEF0) begin
                bad++;
                $display("FAIL single_regrant c=%0d: grant=%b busy=%b hex=%h want 0100/1/0beef0",
                         c, grant, busy, disp_hex);
            end
        end
        req = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (grant !== m_grant() || busy !== (m_owner >= 0) || disp_hex !== m_hex) begin
                bad++;
                $display("FAIL single_release c=%0d: grant=%b busy=%b hex=%h want %b/%0b/%h",
                         c, grant, busy, disp_hex, m_grant(), (m_owner >= 0), m_hex);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        rand_data();
        reset = 1'b1; req = 4'b1111;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            exp_g = N'(1) << ((c / D) % N);
            total++;
            if (grant !== exp_g || disp_hex !== m_hex || disp_src !== 2'(m_src)) begin
                bad++;
                $display("FAIL rr_seq c=%0d: grant=%b hex=%h src=%0d want %b/%h/%0d",
                         c, grant, disp_hex, disp_src, exp_g, m_hex, m_src);
            end
        end
    endtask

    task automatic test_live_freeze();
        rand_data();
        do_reset();
        req_hex[24 +: 24] = 24'h000001;
        req = 4'b0010;
        tick();
        req_hex[24 +: 24] = 24'h000002;
        tick();
        total++;
        if (grant !== 4'b0010 || disp_hex !== 24'h000002) begin
            bad++;
            $display("FAIL live_update: grant=%b hex=%h want 0010/000002", grant, disp_hex);
        end
        req = 4'b0000;
        req_hex[24 +: 24] = 24'h000003;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant !== 4'b0010 || busy !== 1'b1 || disp_hex !== 24'h000002) begin
                bad++;
                $display("FAIL freeze c=%0d: grant=%b busy=%b hex=%h want 0010/1/000002",
                         c, grant, busy, disp_hex);
            end
        end
        tick();
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || disp_hex !== 24'h000002 || disp_src !== 2'd1) begin
            bad++;
            $display("FAIL freeze_expiry: grant=%b busy=%b hex=%h src=%0d want 0000/0/000002/1",
                     grant, busy, disp_hex, disp_src);
        end
    endtask

    task automatic test_nonowner();
        logic [23:0] own_hex;
        rand_data();
        do_reset();
        own_hex = req_hex[72 +: 24];
        req = 4'b1000;
        tick();
        tick();
        req_hex[0 +: 24] = 24'h111111;
        req = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant !== 4'b1000 || disp_hex !== own_hex || disp_hex !== m_hex) begin
                bad++;
                $display("FAIL nonowner_ignored c=%0d: grant=%b hex=%h want 1000/%h", c, grant, disp_hex, own_hex);
            end
        end
        tick();
        total++;
        if (grant !== 4'b0001 || disp_hex !== 24'h111111 || disp_src !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rotate_to_0: grant=%b hex=%h src=%0d busy=%b want 0001/111111/0/1",
                     grant, disp_hex, disp_src, busy);
        end
    endtask

    task automatic test_reset_mid();
        rand_data();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        reset = 1'b1;
        req = 4'b1100;
        tick();
        total++;
        if (grant !== 4'b0000 || disp_blank !== 6'h3F || busy !== 1'b0 || disp_hex !== 24'h0) begin
            bad++;
            $display("FAIL reset_mid: grant=%b blank=%h busy=%b hex=%h want 0000/3f/0/000000",
                     grant, disp_blank, busy, disp_hex);
        end
        reset = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0100 || disp_src !== 2'd2) begin
            bad++;
            $display("FAIL reset_mid_restart: grant=%b src=%0d want 0100/2", grant, disp_src);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 1) == 1) rand_data();
            tick();
            total++;
            if (grant !== m_grant() || busy !== (m_owner >= 0) || disp_hex !== m_hex ||
                disp_blank !== m_blank || disp_src !== 2'(m_src)) begin
                bad++;
                $display("FAIL random c=%0d: grant=%b busy=%b hex=%h blank=%h src=%0d want %b/%0b/%h/%h/%0d",
                         c, grant, busy, disp_hex, disp_blank, disp_src,
                         m_grant(), (m_owner >= 0), m_hex, m_blank, m_src);
            end
            total++;
            if ($countones(grant) > 1 || (busy && grant == '0)) begin
                bad++;
                $display("FAIL random_onehot c=%0d: grant=%b busy=%b want one-hot while busy", c, grant, busy);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; req_hex = '0; req_blank = '0;
        m_owner = -1; m_last = N - 1; m_rem = 0; m_src = 0; m_hex = '0; m_blank = 6'h3F;
        @(negedge CLOCK_50);
        test_reset();
        test_single();
        test_round_robin();
        test_live_freeze();
        test_nonowner();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
